in_line_controller: RTL and testbench
=====================================

Name: in_line_controller

Overview:
- Streaming line-buffer and window generator for a 32x32 8-bit image.
- Buffers incoming raster pixels in a 6-line circular buffer and presents 5x5 windows for a downstream 5x5 convolution engine: valid stride-1 positions only, 28x28 = 784 windows.
- Sits between the pixel source and the conv engine; exposes pointer/state debug outputs.

Parameters:
- IMG_W, 32, image width in pixels.
- IMG_H, 32, image height in rows.
- K, 5, window size.
- NLINES, 6, line-buffer depth in lines.
- Derived, not overridable: OUT_W = IMG_W-K+1 = 28; OUT_H = IMG_H-K+1 = 28.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start pulse.
- o_done  out  1  frame complete; held high in FINISH.
- pixel_in_valid  in  1  pixel_in valid this cycle; no back-pressure to the source.
- pixel_in  in  8  raster-order pixel.
- o_conv_valid  out  1  window outputs valid.
- i_conv_ready  in  1  conv engine accepts the window.
- o_conv_row_start  out  1  current window is column 0 of its output row.
- o_conv_row_end  out  1  current window is column 27.
- window_r_c (r,c = 0..4)  out  8 signed  image pixel at (output_row + r, window_col + c); raw bits.
- o_read_base_ptr  out  3  buffer line holding window row 0.
- o_write_ptr  out  3  buffer line currently being written.
- o_current_state  out  4  state code.
- o_window_col  out  5  current window column, 0..27.
- o_output_row_cnt  out  5  current output row, 0..27.

Behaviour:
- Reset:
  - All registers 0; state IDLE.
  - o_done, o_conv_valid, row_start and row_end are 0.
  - All pointers and counters are 0.
- State codes: IDLE=0, LOAD_INIT=1, CONV_ROW=2, ROLL=3, FINISH=4.
- Write side:
  - Active in every state except IDLE and FINISH. Pixels in IDLE or after the 1024th pixel are ignored.
  - Each pixel_in_valid cycle writes buf[write_ptr][wcol] and increments wcol.
  - At wcol=31: wcol wraps to 0, write_ptr = (write_ptr+1) mod 6, rows_written increments (saturates at 32).
- IDLE: on i_start, clear counters and pointers, go to LOAD_INIT.
- LOAD_INIT: go to CONV_ROW when rows_written >= 5.
- CONV_ROW:
  - o_conv_valid = 1. Windows are combinational reads of buf[(read_base_ptr+r) mod 6][window_col+c], so windows are valid in the same cycle as o_conv_valid.
  - On valid && i_conv_ready, window_col increments.
  - row_start = valid && window_col==0; row_end = valid && window_col==27.
  - Handshake at col 27: window_col resets to 0. Go to FINISH if output_row_cnt==27, else go to ROLL.
  - When ready=0, window, column and valid all hold.
- ROLL:
  - On entry cycle: read_base_ptr = (read_base_ptr+1) mod 6; output_row_cnt increments.
  - Stay in ROLL until rows_written >= output_row_cnt+5, then go to CONV_ROW.
  - o_conv_valid = 0.
- FINISH:
  - o_done = 1 and held.
  - i_start restarts the frame: clear counters, go to LOAD_INIT.
- i_start outside IDLE and FINISH is ignored.
- Overrun: the conv engine must keep pace so write_ptr never wraps onto read_base_ptr while that line is still needed. If it does, data is corrupted; no stall is performed.
- Mid-frame reset: immediate return to reset state.

Optional Feature:
- IN_LINE_OVERRUN_CHK_EN defined:
  - Adds output o_overrun (1 bit, reset 0).
  - Sets sticky when a line wrap would make write_ptr equal read_base_ptr while state is CONV_ROW or ROLL.
  - Cleared by i_start.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: state encoding constants, IMG_W/IMG_H/K/NLINES defaults, pointer-increment-mod-6 function.
- One natural sub-module: in_line_buffer_mem (6x32x8 register array; one write port; 5x5 combinational read by base line and column).

Test Plan:
- Reset, start, 1024 pixels continuous (pixel[i] = i mod 256), ready=1 -> exactly 784 valid windows, then o_done=1.
- First window -> window_0_0 = pixel[0], window_2_2 = pixel[66], window_4_4 = pixel[132]; row_start=1, row=0, col=0.
- Window 29 (row 1, col 0) -> read_base_ptr=1, window_0_0 = pixel[32], row_start=1; window 28 shows row_end=1.
- Stall by toggling i_conv_ready every other cycle during row 0 -> window and col hold while ready=0; no window skipped or duplicated.
- Diagonal 0xEE markers -> window(r,c) with r==c has window_0_0 = window_4_4 = 0xEE.
- Second i_start after FINISH -> o_done drops, second frame again yields 784 windows.

Source files
------------

// File: rtl/in_line_controller_pkg.sv
// Shared definitions for the in-line window generator.
//   - image/window/buffer geometry defaults
//   - FSM state encoding (visible on o_current_state)
//   - write-request struct for the line-buffer memory
//   - circular line-pointer increment
package in_line_controller_pkg;

    localparam int IMG_W_DEF  = 32;
    localparam int IMG_H_DEF  = 32;
    localparam int K_DEF      = 5;
    localparam int NLINES_DEF = 6;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD_INIT = 4'd1,
        S_CONV_ROW  = 4'd2,
        S_ROLL      = 4'd3,
        S_FINISH    = 4'd4
    } state_t;

    typedef struct packed {
        logic       en;
        logic [2:0] line;
        logic [4:0] col;
        logic [7:0] data;
    } wr_req_t;

    // Advance a line pointer around an n-line circular buffer.
    function automatic logic [2:0] ptr_inc(input logic [2:0] p, input int n);
        return (int'(p) == n - 1) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/in_line_buffer_mem.sv
// Circular line buffer: NLINES x IMG_W x 8-bit register array.
//   clk, reset_n : clock, async active-low reset (clears contents)
//   wr           : single write port (enable, line, column, data)
//   base, col    : window origin (buffer line of window row 0, image column)
//   win          : KxK combinational read, win[r][c] = mem[(base+r) mod NLINES][col+c]
module in_line_buffer_mem
    import in_line_controller_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int NLINES = NLINES_DEF,
    parameter int K      = K_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  wr_req_t                    wr,
    input  logic [2:0]                 base,
    input  logic [4:0]                 col,
    output logic [K-1:0][K-1:0][7:0]   win
);

    logic [NLINES-1:0][IMG_W-1:0][7:0] mem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    mem <= '0;
        else if (wr.en)  mem[wr.line][wr.col] <= wr.data;
    end

    generate
        for (genvar r = 0; r < K; r++) begin : g_row
            logic [3:0] sum;
            logic [2:0] line;
            // base+r never exceeds 2*NLINES-2, so one conditional subtract wraps it
            assign sum  = {1'b0, base} + 4'(r);
            assign line = (sum >= 4'(NLINES)) ? 3'(sum - 4'(NLINES)) : sum[2:0];
            for (genvar c = 0; c < K; c++) begin : g_col
                assign win[r][c] = mem[line][5'(col + 5'(c))];
            end
        end
    endgenerate

endmodule

// File: rtl/in_line_controller.sv
// Streaming line buffer + 5x5 window generator for a 32x32 8-bit image.
// Raster pixels fill a 6-line circular buffer; once enough lines are present
// every valid stride-1 window (28x28) is presented to the conv engine with a
// valid/ready handshake. The source has no back-pressure.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   i_start / o_done             frame start pulse / frame complete (held in FINISH)
//   pixel_in_valid, pixel_in     raster pixel stream
//   o_conv_valid, i_conv_ready   window handshake
//   o_conv_row_start/_end        window is column 0 / last column of its output row
//   window_r_c                   image pixel at (output_row+r, window_col+c)
//   o_read_base_ptr, o_write_ptr, o_current_state, o_window_col, o_output_row_cnt : debug
// Optional: define IN_LINE_OVERRUN_CHK_EN to add the sticky o_overrun flag.
module in_line_controller
    import in_line_controller_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int K      = K_DEF,
    parameter int NLINES = NLINES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    output logic              o_done,
    input  logic              pixel_in_valid,
    input  logic [7:0]        pixel_in,
    output logic              o_conv_valid,
    input  logic              i_conv_ready,
    output logic              o_conv_row_start,
    output logic              o_conv_row_end,
    output logic signed [7:0] window_0_0, window_0_1, window_0_2, window_0_3, window_0_4,
    output logic signed [7:0] window_1_0, window_1_1, window_1_2, window_1_3, window_1_4,
    output logic signed [7:0] window_2_0, window_2_1, window_2_2, window_2_3, window_2_4,
    output logic signed [7:0] window_3_0, window_3_1, window_3_2, window_3_3, window_3_4,
    output logic signed [7:0] window_4_0, window_4_1, window_4_2, window_4_3, window_4_4,
    output logic [2:0]        o_read_base_ptr,
    output logic [2:0]        o_write_ptr,
    output logic [3:0]        o_current_state,
    output logic [4:0]        o_window_col,
    output logic [4:0]        o_output_row_cnt
`ifdef IN_LINE_OVERRUN_CHK_EN
    ,
    output logic              o_overrun
`endif
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;

    state_t     state, next_state;
    logic [4:0] wcol, window_col, output_row_cnt;
    logic [2:0] write_ptr, read_base_ptr;
    logic [5:0] rows_written;
    logic       restart, we, line_wrap, hs, last_col;
    wr_req_t    wr;
    logic [K-1:0][K-1:0][7:0] win;

    assign restart   = i_start && (state == S_IDLE || state == S_FINISH);
    // Gating on rows_written < IMG_H both drops pixels past the frame and
    // saturates the row count.
    assign we        = pixel_in_valid && (state inside {S_LOAD_INIT, S_CONV_ROW, S_ROLL})
                       && (rows_written < 6'(IMG_H));
    assign line_wrap = we && (wcol == 5'(IMG_W - 1));
    assign hs        = o_conv_valid && i_conv_ready;
    assign last_col  = (window_col == 5'(OUT_W - 1));
    assign wr        = '{en: we, line: write_ptr, col: wcol, data: pixel_in};

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (i_start) next_state = S_LOAD_INIT;
            S_LOAD_INIT: if (rows_written >= 6'(K)) next_state = S_CONV_ROW;
            S_CONV_ROW:  if (hs && last_col)
                             next_state = (output_row_cnt == 5'(OUT_H - 1)) ? S_FINISH : S_ROLL;
            S_ROLL:      if (rows_written >= {1'b0, output_row_cnt} + 6'(K)) next_state = S_CONV_ROW;
            S_FINISH:    if (i_start) next_state = S_LOAD_INIT;
            default:     next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || restart) begin
            wcol           <= '0;
            write_ptr      <= '0;
            rows_written   <= '0;
            read_base_ptr  <= '0;
            window_col     <= '0;
            output_row_cnt <= '0;
        end else begin
            if (we) begin
                wcol <= line_wrap ? 5'd0 : wcol + 5'd1;
                if (line_wrap) begin
                    write_ptr    <= ptr_inc(write_ptr, NLINES);
                    rows_written <= rows_written + 6'd1;
                end
            end
            if (hs) begin
                if (last_col) begin
                    window_col <= '0;
                    // Roll advances on the transition, so ROLL already sees the
                    // new output row when it checks for the next input line.
                    if (next_state == S_ROLL) begin
                        read_base_ptr  <= ptr_inc(read_base_ptr, NLINES);
                        output_row_cnt <= output_row_cnt + 5'd1;
                    end
                end else begin
                    window_col <= window_col + 5'd1;
                end
            end
        end
    end

`ifdef IN_LINE_OVERRUN_CHK_EN
    // Completing a line whose successor is the oldest line still in use
    // means the next pixel lands on data a pending window needs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     o_overrun <= 1'b0;
        else if (restart) o_overrun <= 1'b0;
        else if (line_wrap && ptr_inc(write_ptr, NLINES) == read_base_ptr
                 && (state == S_CONV_ROW || state == S_ROLL))
            o_overrun <= 1'b1;
    end
`endif

    in_line_buffer_mem #(.IMG_W(IMG_W), .NLINES(NLINES), .K(K)) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr),
        .base    (read_base_ptr),
        .col     (window_col),
        .win     (win)
    );

    assign {window_0_4, window_0_3, window_0_2, window_0_1, window_0_0} = win[0];
    assign {window_1_4, window_1_3, window_1_2, window_1_1, window_1_0} = win[1];
    assign {window_2_4, window_2_3, window_2_2, window_2_1, window_2_0} = win[2];
    assign {window_3_4, window_3_3, window_3_2, window_3_1, window_3_0} = win[3];
    assign {window_4_4, window_4_3, window_4_2, window_4_1, window_4_0} = win[4];

    assign o_done           = (state == S_FINISH);
    assign o_conv_valid     = (state == S_CONV_ROW);
    assign o_conv_row_start = o_conv_valid && (window_col == 5'd0);
    assign o_conv_row_end   = o_conv_valid && last_col;
    assign o_read_base_ptr  = read_base_ptr;
    assign o_write_ptr      = write_ptr;
    assign o_current_state  = state;
    assign o_window_col     = window_col;
    assign o_output_row_cnt = output_row_cnt;

endmodule

// File: tb/tb_in_line_controller.sv
// Bench for in_line_controller: drives whole frames and checks every window
// against an image-level model (window k = pixels at row k/28 + r, column k%28 + c).
module tb_in_line_controller;

    logic clk = 1'b0;
    logic reset_n = 1'b0, i_start = 1'b0, pixel_in_valid = 1'b0, i_conv_ready = 1'b0;
    logic [7:0] pixel_in = 8'h00;
    logic o_done, o_conv_valid, o_conv_row_start, o_conv_row_end;
    logic [4:0][4:0][7:0] wv;
    logic [2:0] o_read_base_ptr, o_write_ptr;
    logic [3:0] o_current_state;
    logic [4:0] o_window_col, o_output_row_cnt;
`ifdef IN_LINE_OVERRUN_CHK_EN
    logic o_overrun;
`endif

    in_line_controller dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .o_done(o_done),
        .pixel_in_valid(pixel_in_valid), .pixel_in(pixel_in),
        .o_conv_valid(o_conv_valid), .i_conv_ready(i_conv_ready),
        .o_conv_row_start(o_conv_row_start), .o_conv_row_end(o_conv_row_end),
        .window_0_0(wv[0][0]), .window_0_1(wv[0][1]), .window_0_2(wv[0][2]), .window_0_3(wv[0][3]), .window_0_4(wv[0][4]),
        .window_1_0(wv[1][0]), .window_1_1(wv[1][1]), .window_1_2(wv[1][2]), .window_1_3(wv[1][3]), .window_1_4(wv[1][4]),
        .window_2_0(wv[2][0]), .window_2_1(wv[2][1]), .window_2_2(wv[2][2]), .window_2_3(wv[2][3]), .window_2_4(wv[2][4]),
        .window_3_0(wv[3][0]), .window_3_1(wv[3][1]), .window_3_2(wv[3][2]), .window_3_3(wv[3][3]), .window_3_4(wv[3][4]),
        .window_4_0(wv[4][0]), .window_4_1(wv[4][1]), .window_4_2(wv[4][2]), .window_4_3(wv[4][3]), .window_4_4(wv[4][4]),
        .o_read_base_ptr(o_read_base_ptr), .o_write_ptr(o_write_ptr),
        .o_current_state(o_current_state), .o_window_col(o_window_col),
        .o_output_row_cnt(o_output_row_cnt)
`ifdef IN_LINE_OVERRUN_CHK_EN
        , .o_overrun(o_overrun)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [199:0] win;
        logic         rdy, rs, re;
        logic [4:0]   row, col;
        logic [2:0]   rbp;
        int           cyc;
    } rec_t;

    rec_t recs[$];   // every cycle with o_conv_valid
    rec_t hsq[$];    // handshake cycles only, padded to 800 entries
    int   n_hs, timed_out;
    int   n_vec = 0, n_err = 0;
    logic [7:0] img [1024];

    // Expected window at output (row, col); byte (r*5+c) is pixel (row+r, col+c).
    function automatic logic [199:0] model_win(input int row, input int col);
        logic [199:0] v;
        v = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                int idx;
                idx = (row + r) * 32 + col + c;
                v[(r * 5 + c) * 8 +: 8] = (idx < 1024) ? img[idx] : 8'h00;
            end
        return v;
    endfunction

    task automatic do_start();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    // mode 0: every cycle; 1: every other cycle; 2: random 1 in 4
    task automatic drive_pixels(input int mode);
        int i;
        bit emit, ph;
        i = 0; ph = 1'b0;
        while (i < 1024) begin
            @(posedge clk); #1;
            ph = ~ph;
            case (mode)
                0:       emit = 1'b1;
                1:       emit = ph;
                default: emit = ($urandom_range(0, 3) == 0);
            endcase
            if (emit) begin
                pixel_in_valid = 1'b1; pixel_in = img[i]; i++;
            end else begin
                pixel_in_valid = 1'b0; pixel_in = 8'($urandom);
            end
        end
        @(posedge clk); #1 pixel_in_valid = 1'b0;
    endtask

    // mode 0: ready=1; 1: ready toggles during output row 0; 2: random 3 in 4
    task automatic collect(input int mode);
        int cyc;
        rec_t r, z;
        recs.delete(); hsq.delete();
        timed_out = 0; cyc = 0;
        z = '{default: 0};
        while (1) begin
            @(posedge clk); #1;
            case (mode)
                0:       i_conv_ready = 1'b1;
                1:       i_conv_ready = (o_output_row_cnt != 5'd0) || (cyc % 2 == 1);
                default: i_conv_ready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            if (o_conv_valid) begin
                r.win = wv; r.rdy = i_conv_ready; r.rs = o_conv_row_start; r.re = o_conv_row_end;
                r.row = o_output_row_cnt; r.col = o_window_col; r.rbp = o_read_base_ptr; r.cyc = cyc;
                recs.push_back(r);
                if (i_conv_ready) hsq.push_back(r);
            end
            if (o_done) break;
            cyc++;
            if (cyc >= 10000) begin timed_out = 1; break; end
        end
        n_hs = hsq.size();
        while (hsq.size() < 800) hsq.push_back(z);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({o_current_state, o_done, o_conv_valid, o_conv_row_start, o_conv_row_end} !== 8'h00) begin
            n_err++; $display("FAIL reset_ctrl: got state=%0d done=%b valid=%b rs=%b re=%b, want all 0",
                              o_current_state, o_done, o_conv_valid, o_conv_row_start, o_conv_row_end);
        end
        n_vec++;
        if ({o_read_base_ptr, o_write_ptr, o_window_col, o_output_row_cnt} !== 16'h0) begin
            n_err++; $display("FAIL reset_ptrs: got rbp=%0d wp=%0d col=%0d row=%0d, want 0",
                              o_read_base_ptr, o_write_ptr, o_window_col, o_output_row_cnt);
        end
`ifdef IN_LINE_OVERRUN_CHK_EN
        n_vec++;
        if (o_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
`endif
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (o_current_state !== 4'd0) begin
            n_err++; $display("FAIL post_reset_state: got %0d want 0", o_current_state);
        end
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1 pixel_in_valid = 1'b1; pixel_in = 8'(i);
        end
        @(posedge clk); #1 pixel_in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({o_current_state, o_write_ptr, o_conv_valid} !== 8'h00) begin
            n_err++; $display("FAIL idle_ignore: got state=%0d wp=%0d valid=%b, want 0/0/0",
                              o_current_state, o_write_ptr, o_conv_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_start();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1 pixel_in_valid = 1'b1; pixel_in = 8'(i);
        end
        @(posedge clk); #1 pixel_in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({o_current_state, o_write_ptr} !== {4'd1, 3'd1}) begin
            n_err++; $display("FAIL partial_load: got state=%0d wp=%0d, want 1/1", o_current_state, o_write_ptr);
        end
        do_start();   // ignored outside IDLE/FINISH
        @(negedge clk);
        n_vec++;
        if ({o_current_state, o_write_ptr} !== {4'd1, 3'd1}) begin
            n_err++; $display("FAIL start_ignored: got state=%0d wp=%0d, want 1/1", o_current_state, o_write_ptr);
        end
        #1 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({o_current_state, o_write_ptr, o_done} !== 8'h00) begin
            n_err++; $display("FAIL mid_reset: got state=%0d wp=%0d done=%b, want 0", o_current_state, o_write_ptr, o_done);
        end
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_full_frame();
        logic [199:0] exp;
        for (int i = 0; i < 1024; i++) img[i] = 8'(i % 256);
        do_start();
        fork drive_pixels(0); collect(0); join
        n_vec++;
        if (timed_out !== 0 || n_hs !== 784) begin
            n_err++; $display("FAIL ramp_count: got %0d windows (timeout=%0d), want 784", n_hs, timed_out);
        end
        for (int k = 0; k < 784; k++) begin
            exp = model_win(k / 28, k % 28);
            n_vec++;
            if ({hsq[k].row, hsq[k].col, hsq[k].rs, hsq[k].re, hsq[k].win} !==
                {5'(k / 28), 5'(k % 28), k % 28 == 0, k % 28 == 27, exp}) begin
                n_err++; $display("FAIL ramp_win[%0d]: got row=%0d col=%0d rs=%b re=%b win=%h, want row=%0d col=%0d win=%h",
                                  k, hsq[k].row, hsq[k].col, hsq[k].rs, hsq[k].re, hsq[k].win, k / 28, k % 28, exp);
            end
        end
        n_vec++;
        if ({hsq[0].win[7:0], hsq[0].win[12*8 +: 8], hsq[0].win[24*8 +: 8], hsq[0].rs} !==
            {img[0], img[66], img[132], 1'b1}) begin
            n_err++; $display("FAIL first_win: got w00=%0d w22=%0d w44=%0d rs=%b, want %0d %0d %0d 1",
                              hsq[0].win[7:0], hsq[0].win[12*8 +: 8], hsq[0].win[24*8 +: 8], hsq[0].rs,
                              img[0], img[66], img[132]);
        end
        n_vec++;
        if ({hsq[27].re, hsq[28].rbp, hsq[28].win[7:0], hsq[28].rs} !== {1'b1, 3'd1, img[32], 1'b1}) begin
            n_err++; $display("FAIL row1_start: got re27=%b rbp=%0d w00=%0d rs=%b, want 1 1 %0d 1",
                              hsq[27].re, hsq[28].rbp, hsq[28].win[7:0], hsq[28].rs, img[32]);
        end
        n_vec++;
        if ({o_done, o_current_state, o_write_ptr, o_read_base_ptr, o_output_row_cnt} !==
            {1'b1, 4'd4, 3'd2, 3'd3, 5'd27}) begin
            n_err++; $display("FAIL finish_state: got done=%b st=%0d wp=%0d rbp=%0d row=%0d, want 1 4 2 3 27",
                              o_done, o_current_state, o_write_ptr, o_read_base_ptr, o_output_row_cnt);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (o_done !== 1'b1) begin n_err++; $display("FAIL done_held: got %b want 1", o_done); end
`ifdef IN_LINE_OVERRUN_CHK_EN
        n_vec++;
        if (o_overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clean: got %b want 0", o_overrun); end
`endif
    endtask

    task automatic test_stall();
        logic [199:0] exp;
        int n_stall;
        for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
        do_start();
        fork drive_pixels(1); collect(1); join
        n_vec++;
        if (timed_out !== 0 || n_hs !== 784) begin
            n_err++; $display("FAIL stall_count: got %0d windows (timeout=%0d), want 784", n_hs, timed_out);
        end
        for (int k = 0; k < 784; k++) begin
            exp = model_win(k / 28, k % 28);
            n_vec++;
            if ({hsq[k].row, hsq[k].col, hsq[k].win} !== {5'(k / 28), 5'(k % 28), exp}) begin
                n_err++; $display("FAIL stall_win[%0d]: got row=%0d col=%0d win=%h, want row=%0d col=%0d win=%h",
                                  k, hsq[k].row, hsq[k].col, hsq[k].win, k / 28, k % 28, exp);
            end
        end
        n_stall = 0;
        for (int i = 0; i + 1 < recs.size(); i++) begin
            if (!recs[i].rdy) begin
                n_stall++;
                n_vec++;
                if ({recs[i+1].cyc, recs[i+1].col, recs[i+1].win} !== {recs[i].cyc + 1, recs[i].col, recs[i].win}) begin
                    n_err++; $display("FAIL stall_hold[%0d]: got cyc=%0d col=%0d win=%h, want cyc=%0d col=%0d win=%h",
                                      i, recs[i+1].cyc, recs[i+1].col, recs[i+1].win,
                                      recs[i].cyc + 1, recs[i].col, recs[i].win);
                end
            end
        end
        n_vec++;
        if (n_stall < 10) begin n_err++; $display("FAIL stall_seen: got %0d stalls, want >= 10", n_stall); end
    endtask

    task automatic test_diagonal();
        logic [199:0] exp;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) begin
                logic [7:0] v;
                v = 8'($urandom);
                if (v == 8'hEE) v = 8'h00;
                img[y * 32 + x] = (y == x) ? 8'hEE : v;
            end
        do_start();
        fork drive_pixels(2); collect(2); join
        n_vec++;
        if (timed_out !== 0 || n_hs !== 784) begin
            n_err++; $display("FAIL diag_count: got %0d windows (timeout=%0d), want 784", n_hs, timed_out);
        end
        for (int k = 0; k < 784; k++) begin
            exp = model_win(k / 28, k % 28);
            n_vec++;
            if (hsq[k].win !== exp) begin
                n_err++; $display("FAIL diag_win[%0d]: got %h want %h", k, hsq[k].win, exp);
            end
        end
        for (int d = 0; d < 28; d++) begin
            n_vec++;
            if ({hsq[d * 29].win[7:0], hsq[d * 29].win[24*8 +: 8]} !== 16'hEEEE) begin
                n_err++; $display("FAIL diag_marker[%0d]: got w00=%h w44=%h, want ee ee",
                                  d, hsq[d * 29].win[7:0], hsq[d * 29].win[24*8 +: 8]);
            end
        end
    endtask

    task automatic test_restart();
        logic [199:0] exp;
        @(negedge clk);
        n_vec++;
        if (o_done !== 1'b1) begin n_err++; $display("FAIL pre_restart_done: got %b want 1", o_done); end
        for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
        do_start();
        @(negedge clk);
        n_vec++;
        if ({o_done, o_current_state, o_write_ptr, o_output_row_cnt} !== {1'b0, 4'd1, 3'd0, 5'd0}) begin
            n_err++; $display("FAIL restart: got done=%b st=%0d wp=%0d row=%0d, want 0 1 0 0",
                              o_done, o_current_state, o_write_ptr, o_output_row_cnt);
        end
        fork drive_pixels(2); collect(2); join
        n_vec++;
        if (timed_out !== 0 || n_hs !== 784) begin
            n_err++; $display("FAIL restart_count: got %0d windows (timeout=%0d), want 784", n_hs, timed_out);
        end
        for (int k = 0; k < 784; k++) begin
            exp = model_win(k / 28, k % 28);
            n_vec++;
            if ({hsq[k].row, hsq[k].col, hsq[k].win} !== {5'(k / 28), 5'(k % 28), exp}) begin
                n_err++; $display("FAIL restart_win[%0d]: got row=%0d col=%0d win=%h, want row=%0d col=%0d win=%h",
                                  k, hsq[k].row, hsq[k].col, hsq[k].win, k / 28, k % 28, exp);
            end
        end
        n_vec++;
        if (o_done !== 1'b1) begin n_err++; $display("FAIL restart_done: got %b want 1", o_done); end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_mid_reset();
        test_full_frame();
        test_stall();
        test_diagonal();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
